// File: rtl/wb_uart_tx_if.sv
// wb_uart_tx_if: Wishbone slave bus bundle for wb_uart_tx; signal names follow the core's bus pinout.
interface wb_uart_tx_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;
  modport master (output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i, input wb_dat_o, wb_ack_o);
  modport slave  (input wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i, output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone-controlled 8N1 UART transmitter with TX queue and programmable baud divisor.
// Define WB_UART_TX_FIFO_EN for a 2^DEPTH_LOG2-entry FIFO; otherwise a single holding register is used.
module wb_uart_tx #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  wb_uart_tx_if.slave   wb,
  output logic          uart_tx,
  output logic          tx_irq
);
`ifdef WB_UART_TX_FIFO_EN
  localparam int CAP = 1 << DEPTH_LOG2;
`else
  localparam int CAP = 1;
`endif
  localparam int LW = DEPTH_LOG2 + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state, state_n;
  logic [LW-1:0] level;
  logic [7:0]    head, sh, sh_n;
  logic [15:0]   div, cur_div, cur_div_n, cnt, cnt_n;
  logic [2:0]    bidx, bidx_n;
  logic [1:0]    reg_sel;
  logic [31:0]   rd, status;
  logic          ovf, acc, wr, push_req, push, pop, full, empty, bit_end, ovf_clr, tx_n;
  logic          unused;
  assign unused   = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:16], wb.wb_sel_i[3:2]};
  assign acc      = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign wr       = acc & wb.wb_we_i;
  assign reg_sel  = wb.wb_adr_i[3:2];
  assign push_req = wr & (reg_sel == 2'd0) & wb.wb_sel_i[0];
  assign empty    = level == '0;
  assign full     = level == LW'(CAP);
  // a pop on the same edge frees the slot, so a full queue still takes the write
  assign push     = push_req & (~full | pop);
  assign ovf_clr  = wr & (reg_sel == 2'd1) & wb.wb_sel_i[0] & wb.wb_dat_i[3];
  assign bit_end  = cnt == cur_div - 16'd1;
  assign tx_irq   = empty & (state == IDLE);
  assign status   = (32'(level) << 4) | {28'd0, ovf, empty, full, state != IDLE};
  assign rd       = (reg_sel == 2'd1) ? status : (reg_sel == 2'd2) ? {16'd0, div} : 32'd0;
`ifdef WB_UART_TX_FIFO_EN
  logic [7:0]            mem [CAP];
  logic [DEPTH_LOG2-1:0] wp, rp;
  always_ff @(posedge sys_clk)
    if (push) mem[wp] <= wb.wb_dat_i[7:0];
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + DEPTH_LOG2'(push);
      rp <= rp + DEPTH_LOG2'(pop);
    end
  assign head = mem[rp];
`else
  logic [7:0] hold;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) hold <= 8'd0;
    else if (push) hold <= wb.wb_dat_i[7:0];
  assign head = hold;
`endif
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      level       <= '0;
      ovf         <= 1'b0;
      div         <= DIV_RESET;
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= 32'd0;
    end else begin
      level       <= level + LW'(push) - LW'(pop);
      ovf         <= (push_req & ~push) | (ovf & ~ovf_clr);
      wb.wb_ack_o <= acc;
      wb.wb_dat_o <= (acc & ~wb.wb_we_i) ? rd : 32'd0;
      if (wr & (reg_sel == 2'd2) & wb.wb_sel_i[0]) div[7:0]  <= wb.wb_dat_i[7:0];
      if (wr & (reg_sel == 2'd2) & wb.wb_sel_i[1]) div[15:8] <= wb.wb_dat_i[15:8];
    end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state   <= IDLE;
      sh      <= 8'd0;
      cnt     <= 16'd0;
      bidx    <= 3'd0;
      cur_div <= DIV_RESET;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      cnt     <= cnt_n;
      bidx    <= bidx_n;
      cur_div <= cur_div_n;
      uart_tx <= tx_n;
    end
  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    sh_n      = sh;
    bidx_n    = bidx;
    cur_div_n = cur_div;
    cnt_n     = bit_end ? 16'd0 : cnt + 16'd1;
    case (state)
      IDLE: begin
        cnt_n = 16'd0;
        if (!empty) begin
          state_n = START;
          pop     = 1'b1;
        end
      end
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        bidx_n = bidx + 3'd1;
        sh_n   = sh >> 1;
        if (bidx == 3'd7) state_n = STOP;
      end
      default: if (bit_end) begin
        state_n = empty ? IDLE : START;
        pop     = ~empty;
      end
    endcase
    // the divisor is sampled only here, so a frame in flight keeps its bit time
    if (pop) begin
      sh_n      = head;
      cur_div_n = (div == 16'd0) ? 16'd1 : div;
      cnt_n     = 16'd0;
    end
    tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? sh_n[0] : 1'b1;
  end
endmodule

// File: tb/tb_wb_uart_tx.sv
// tb_wb_uart_tx: directed plus randomized bench for wb_uart_tx against a frame-schedule reference model.
module tb_wb_uart_tx;
`ifdef WB_UART_TX_FIFO_EN
  localparam int CAP = 16;
`else
  localparam int CAP = 1;
`endif
  localparam int DIVR = 16;
  localparam int TN = 40000;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic uart_tx, tx_irq;
  wb_uart_tx_if wb();
  wb_uart_tx #(.DEPTH_LOG2(4), .DIV_RESET(16'd16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wb(wb), .uart_tx(uart_tx), .tx_irq(tx_irq));
  always #5 sys_clk = ~sys_clk;
  int   cyc = 0;
  logic trace [TN];
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) if (cyc < TN) trace[cyc] <= uart_tx;
  int   n_ack = 0, n_dbl = 0, n_datbad = 0;
  logic ack_q = 1'b0;
  always @(negedge sys_clk) begin
    if (wb.wb_ack_o) n_ack <= n_ack + 1;
    if (wb.wb_ack_o && ack_q) n_dbl <= n_dbl + 1;
    if (!wb.wb_ack_o && wb.wb_dat_o != 32'd0) n_datbad <= n_datbad + 1;
    ack_q <= wb.wb_ack_o;
  end
  int n_chk = 0, n_fail = 0, n_xfer = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // reference model: accepted bytes with their push edge, divisor writes, derived frame starts
  int          push_c[$];
  logic [7:0]  push_b[$];
  int          dw_c[$];
  int          dw_v[$];
  int          st[$];
  bit          ovf_m;
  logic [15:0] div_raw;
  int          epoch;
  function automatic int div_at(int s);
    int v = DIVR;
    foreach (dw_c[i]) if (dw_c[i] < s) v = dw_v[i];
    return (v == 0) ? 1 : v;
  endfunction
  function automatic void resolve();
    int pe = 0, s;
    st.delete();
    foreach (push_c[i]) begin
      s = push_c[i] + 1;
      if (i > 0 && pe > s) s = pe;
      st.push_back(s);
      pe = s + 10 * div_at(s);
    end
  endfunction
  function automatic int level_at(int c);
    int n = 0;
    foreach (push_c[i]) if (push_c[i] <= c && st[i] > c) n++;
    return n;
  endfunction
  function automatic bit busy_at(int c);
    bit b = 0;
    foreach (st[i]) if (st[i] <= c && c < st[i] + 10 * div_at(st[i])) b = 1;
    return b;
  endfunction
  function automatic int last_end();
    return (st.size() == 0) ? 0 : st[st.size()-1] + 10 * div_at(st[st.size()-1]);
  endfunction
  function automatic void model_reset();
    push_c.delete(); push_b.delete(); dw_c.delete(); dw_v.delete(); st.delete();
    ovf_m = 0;
    div_raw = 16'(DIVR);
  endfunction
  time         last_done = 0;
  int          x_a;
  logic [31:0] x_r;
  task automatic xfer(input bit we, input logic [3:0] off, input logic [31:0] d, input logic [3:0] sel);
    int lat = 0;
    bit b2b = (last_done == $time);
    logic [31:0] junk = $urandom;
    x_a = -1;
    wb.wb_adr_i = (junk & 32'hFFFF_FFF3) | {28'd0, off};
    wb.wb_dat_i = d;
    wb.wb_sel_i = sel;
    wb.wb_we_i  = we;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    for (int i = 1; i <= 8 && x_a < 0; i++) begin
      @(negedge sys_clk);
      if (wb.wb_ack_o) begin
        x_a = cyc;
        lat = i;
      end
    end
    x_r = wb.wb_dat_o;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    last_done = $time;
    n_xfer++;
    chk("ack_latency", lat, b2b ? 2 : 1);
  endtask
  task automatic wr_data(input logic [7:0] b, input logic [3:0] sel);
    logic [31:0] d = $urandom;
    int lvl;
    bit pop_now = 0;
    xfer(1'b1, 4'h0, {d[31:8], b}, sel);
    if (x_a >= 0 && sel[0]) begin
      resolve();
      lvl = level_at(x_a - 1);
      foreach (st[i]) if (st[i] == x_a) pop_now = 1;
      if (lvl < CAP || pop_now) begin
        push_c.push_back(x_a);
        push_b.push_back(b);
      end else ovf_m = 1;
    end
  endtask
  task automatic wr_div(input logic [15:0] v);
    logic [31:0] d = $urandom;
    xfer(1'b1, 4'h8, {d[31:16], v}, 4'hF);
    if (x_a >= 0) begin
      dw_c.push_back(x_a);
      dw_v.push_back(int'(v));
      div_raw = v;
    end
  endtask
  task automatic wr_stat(input logic [31:0] v);
    xfer(1'b1, 4'h4, v, 4'hF);
    if (x_a >= 0 && v[3]) ovf_m = 0;
  endtask
  task automatic rd_stat(input string tag);
    int l;
    logic [31:0] e;
    xfer(1'b0, 4'h4, $urandom, 4'hF);
    resolve();
    l = level_at(x_a - 1);
    e = (32'(l) << 4) | {28'd0, ovf_m, l == 0, l == CAP, busy_at(x_a - 1)};
    chk(tag, x_r, e);
  endtask
  task automatic rd_div(input string tag);
    xfer(1'b0, 4'h8, $urandom, 4'hF);
    chk(tag, x_r, {16'd0, div_raw});
  endtask
  task automatic rd_zero(input string tag, input logic [3:0] off);
    xfer(1'b0, off, $urandom, 4'hF);
    chk(tag, x_r, 32'd0);
  endtask
  task automatic chk_irq();
    resolve();
    chk("tx_irq", tx_irq, level_at(cyc) == 0 && !busy_at(cyc));
  endtask
  task automatic wait_idle();
    int e;
    resolve();
    e = last_end();
    if (e > cyc + 20000) begin
      chk("idle_bound", 0, 1);
      e = cyc;
    end
    while (cyc < e + 2) @(negedge sys_clk);
    chk_irq();
  endtask
  task automatic check_line(input int from, input int to);
    int mism = 0, s, d, k;
    logic e;
    logic [7:0] ob;
    resolve();
    for (int c = from; c <= to && c < TN; c++) begin
      e = 1'b1;
      foreach (st[i]) begin
        s = st[i];
        d = div_at(s);
        if (c >= s && c < s + 10 * d) begin
          k = (c - s) / d;
          e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : push_b[i][k-1];
        end
      end
      if (trace[c] !== e) mism++;
    end
    chk("line_waveform", mism, 0);
    foreach (st[i]) begin
      s = st[i];
      d = div_at(s);
      if (s >= from && s + 10 * d - 1 <= to && s + 10 * d < TN) begin
        for (int b = 0; b < 8; b++) ob[b] = trace[s + (b + 1) * d + d / 2];
        chk("frame_byte", ob, push_b[i]);
      end
    end
  endtask
  initial begin
    int a0;
    logic [9:0] pat;
    int mism;
    logic [31:0] rv;
    wb.wb_adr_i = 32'd0; wb.wb_dat_i = 32'd0; wb.wb_sel_i = 4'd0;
    wb.wb_cyc_i = 1'b0;  wb.wb_stb_i = 1'b0;  wb.wb_we_i = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_ack", wb.wb_ack_o, 0);
    chk("rst_dat_o", wb.wb_dat_o, 0);
    chk("rst_irq", tx_irq, 1);
    sys_rst_n = 1'b1;
    epoch = cyc + 1;
    rd_stat("status_reset");
    rd_div("div_reset");
    rd_zero("data_read", 4'h0);
    rd_zero("resv_read", 4'hC);
    // single 0x41 frame at DIV=4, waveform checked against the literal bit pattern too
    wr_div(16'd4);
    wr_data(8'h41, 4'hF);
    a0 = x_a;
    chk_irq();
    wait_idle();
    pat = 10'b1010000010;
    mism = 0;
    for (int k = 0; k < 40; k++) if (trace[a0 + 1 + k] !== pat[k / 4]) mism++;
    chk("frame41_pattern", mism, 0);
    chk("frame41_pre_high", trace[a0], 1);
    chk("frame41_post_high", trace[a0 + 41], 1);
    check_line(epoch, cyc - 1);
    // three queued writes, status mid-frame, overflow clear
    wr_data(8'hA5, 4'hF);
    wr_data(8'h5A, 4'hF);
    wr_data(8'h0F, 4'hF);
    rd_stat("status_3q");
    wr_data(8'hEE, 4'hE);
    xfer(1'b1, 4'hC, 32'hFFFF_FFFF, 4'hF);
    rd_div("div_after_resv");
    wr_stat(32'h8);
    rd_stat("status_w1c");
    wait_idle();
    check_line(epoch, cyc - 1);
    // divisor change mid-frame
    wr_div(16'd4);
    wr_data(8'h3C, 4'hF);
    wr_data(8'hC3, 4'hF);
    repeat (10) @(negedge sys_clk);
    wr_div(16'd2);
    rd_div("div_mid");
    wait_idle();
    check_line(epoch, cyc - 1);
    // seventeen back-to-back writes at the reset divisor
    wr_div(16'd16);
    for (int i = 0; i <= 16; i++) wr_data(8'(i), 4'hF);
    rd_stat("status_17");
    wr_stat(32'h8);
    rd_stat("status_17_w1c");
    wait_idle();
    check_line(epoch, cyc - 1);
    // holding-register scenario: 0x55, 0xAA, third write
    wr_div(16'd4);
    wr_data(8'h55, 4'hF);
    wr_data(8'hAA, 4'hF);
    wr_data(8'h33, 4'hF);
    rd_stat("status_55aa");
    wait_idle();
    check_line(epoch, cyc - 1);
    wr_stat(32'h8);
    // divisor zero behaves as one
    wr_div(16'd0);
    wr_data(8'h96, 4'hF);
    wait_idle();
    check_line(epoch, cyc - 1);
    rd_div("div_zero");
    // reset in the middle of the data bits
    wr_div(16'd4);
    wr_data(8'hF0, 4'hF);
    a0 = x_a;
    while (cyc < a0 + 12) @(negedge sys_clk);
    chk("pre_rst_low", uart_tx, 0);
    check_line(epoch, cyc - 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_async_tx", uart_tx, 1);
    chk("rst_async_irq", tx_irq, 1);
    chk("rst_async_ack", wb.wb_ack_o, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    epoch = cyc + 1;
    rd_stat("status_post_rst");
    rd_div("div_post_rst");
    repeat (60) @(negedge sys_clk);
    check_line(epoch, cyc - 1);
    // randomized traffic
    repeat (90) begin
      rv = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: wr_data(rv[7:0], rv[11:8]);
        4: rd_stat("status_rand");
        5: wr_div(16'($urandom_range(0, 5)));
        6: repeat ($urandom_range(1, 40)) @(negedge sys_clk);
        7: rd_div("div_rand");
        8: wr_stat(rv & 32'h0000_000F);
        default: chk_irq();
      endcase
    end
    wait_idle();
    check_line(epoch, cyc - 1);
    repeat (2) @(negedge sys_clk);
    chk("ack_single_cycle", n_dbl, 0);
    chk("ack_count", n_ack, n_xfer);
    chk("dat_o_zero_idle", n_datbad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
